// File: rtl/keyscan_pkg.sv
// keyscan_pkg: scanner FSM states and the event byte format shared with the uart reporter.
package keyscan_pkg;
  typedef enum logic [2:0] {S_WAIT, S_REQ, S_SETTLE, S_SAMPLE, S_RELEASE, S_REPORT} state_e;
  typedef struct packed {
    logic       pressed;
    logic [3:0] col;
    logic [2:0] row;
  } key_event_t;
  function automatic key_event_t pack_event(input logic pressed, input logic [3:0] col, input logic [2:0] row);
    return '{pressed: pressed, col: col, row: row};
  endfunction
endpackage

// File: rtl/keyscan_debounce.sv
// keyscan_debounce: per-key scan counters; a stable bit may flip only after
// DEBOUNCE_SCANS consecutive samples of its column disagree with it.
module keyscan_debounce
  import keyscan_pkg::*;
#(
  parameter int N_COLS = 8,
  parameter int N_ROWS = 8,
  parameter int DEBOUNCE_SCANS = 3,
  localparam int CLW = $clog2(N_COLS),
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd_i,
  input  logic [CLW-1:0]    col_i,
  input  logic [N_ROWS-1:0] raw_i,
  input  logic [N_ROWS-1:0] stable_i,
  output logic [N_ROWS-1:0] target_o
);
  logic [N_COLS-1:0][N_ROWS-1:0][DW-1:0] cnt_q, cnt_d;
  // A counter left at DEBOUNCE_SCANS marks a flip already reported; a further mismatch restarts at 1.
  always_comb begin
    cnt_d = cnt_q;
    target_o = stable_i;
    for (int r = 0; r < N_ROWS; r++) begin
      if (upd_i)
        cnt_d[col_i][r] = raw_i[r] == stable_i[r] ? '0 :
                          cnt_q[col_i][r] == DW'(DEBOUNCE_SCANS) ? DW'(1) : cnt_q[col_i][r] + DW'(1);
      if (cnt_q[col_i][r] == DW'(DEBOUNCE_SCANS)) target_o[r] = raw_i[r];
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/keyboard_matrix_scanner.sv
// keyboard_matrix_scanner: column-at-a-time key matrix scanner borrowing the LCD data bus.
// Define KEYSCAN_DEBOUNCE_EN to filter every key through keyscan_debounce before reporting.
module keyboard_matrix_scanner
  import keyscan_pkg::*;
#(
  parameter int N_COLS = 8,
  parameter int N_ROWS = 8,
  parameter int SCAN_INTERVAL = 48000,
  parameter int SETTLE_CYCLES = 48,
`ifdef KEYSCAN_DEBOUNCE_EN
  parameter int DEBOUNCE_SCANS = 3,
`endif
  localparam int CLW = $clog2(N_COLS),
  localparam int RW = N_ROWS > 1 ? $clog2(N_ROWS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              bus_req,
  input  logic              bus_ack,
  output logic              bus_release,
  output logic [N_COLS-1:0] col_drive,
  input  logic [N_ROWS-1:0] row_in,
  output logic              key_strobe,
  output logic              key_pressed,
  output logic [CLW-1:0]    key_col,
  output logic [RW-1:0]     key_row,
  output logic [CLW-1:0]    scan_col
);
  localparam int CW = $clog2((SCAN_INTERVAL > SETTLE_CYCLES ? SCAN_INTERVAL : SETTLE_CYCLES) + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CLW-1:0] col_q, col_d, kcol_q, kcol_d;
  logic [RW-1:0] krow_q, krow_d, low;
  logic req_q, req_d, rel_q, rel_d, stb_q, stb_d, prs_q, prs_d;
  logic [N_COLS-1:0] drv_q, drv_d;
  logic [N_ROWS-1:0] smp_q, smp_d, target, diff;
  logic [N_COLS-1:0][N_ROWS-1:0] mat_q, mat_d;
`ifdef KEYSCAN_DEBOUNCE_EN
  keyscan_debounce #(
    .N_COLS(N_COLS), .N_ROWS(N_ROWS), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk(clk), .reset(reset), .upd_i(state_q == S_SAMPLE), .col_i(col_q),
    .raw_i(smp_q), .stable_i(mat_q[col_q]), .target_o(target)
  );
`else
  assign target = smp_q;
`endif
  assign diff = target ^ mat_q[col_q];
  always_comb begin
    low = '0;
    for (int r = N_ROWS - 1; r >= 0; r--) if (diff[r]) low = RW'(r);
  end
  // RELEASE emits the first event and REPORT the rest; an empty diff skips straight to WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    col_d = col_q;
    req_d = req_q;
    rel_d = rel_q;
    drv_d = drv_q;
    smp_d = smp_q;
    mat_d = mat_q;
    stb_d = 1'b0;
    prs_d = prs_q;
    kcol_d = kcol_q;
    krow_d = krow_q;
    unique case (state_q)
      S_WAIT:
        if (cnt_q == CW'(SCAN_INTERVAL - 1)) begin
          cnt_d = '0;
          req_d = 1'b1;
          state_d = S_REQ;
        end else cnt_d = cnt_q + CW'(1);
      S_REQ:
        if (bus_ack) begin
          rel_d = 1'b1;
          drv_d = ~(N_COLS'(1) << col_q);
          state_d = S_SETTLE;
        end
      S_SETTLE:
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          cnt_d = '0;
          smp_d = ~row_in;
          state_d = S_SAMPLE;
        end else cnt_d = cnt_q + CW'(1);
      S_SAMPLE: begin
        drv_d = '1;
        rel_d = 1'b0;
        req_d = 1'b0;
        state_d = S_RELEASE;
      end
      S_RELEASE, S_REPORT:
        if (|diff) begin
          stb_d = 1'b1;
          prs_d = target[low];
          kcol_d = col_q;
          krow_d = low;
          mat_d[col_q][low] = target[low];
          state_d = S_REPORT;
        end else begin
          col_d = col_q == CLW'(N_COLS - 1) ? '0 : col_q + CLW'(1);
          state_d = S_WAIT;
        end
      default: state_d = S_WAIT;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_WAIT;
      cnt_q <= '0;
      col_q <= '0;
      req_q <= 1'b0;
      rel_q <= 1'b0;
      drv_q <= '1;
      smp_q <= '0;
      mat_q <= '0;
      stb_q <= 1'b0;
      prs_q <= 1'b0;
      kcol_q <= '0;
      krow_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      col_q <= col_d;
      req_q <= req_d;
      rel_q <= rel_d;
      drv_q <= drv_d;
      smp_q <= smp_d;
      mat_q <= mat_d;
      stb_q <= stb_d;
      prs_q <= prs_d;
      kcol_q <= kcol_d;
      krow_q <= krow_d;
    end
  end
  assign bus_req = req_q;
  assign bus_release = rel_q;
  assign col_drive = drv_q;
  assign key_strobe = stb_q;
  assign key_pressed = prs_q;
  assign key_col = kcol_q;
  assign key_row = krow_q;
  assign scan_col = col_q;
endmodule

// File: tb/tb_keyboard_matrix_scanner.sv
// tb_keyboard_matrix_scanner: randomized scans of a modelled key matrix checked against a per-scan event model.
module tb_keyboard_matrix_scanner;
  localparam int NC = 8, NR = 8, SI = 10, ST = 2, DS = 3;
  logic clk = 0, reset = 0, bus_ack = 0;
  logic bus_req, bus_release, key_strobe, key_pressed;
  logic [NC-1:0] col_drive;
  logic [NR-1:0] row_in;
  logic [2:0] key_col, key_row, scan_col;
  logic [NC-1:0][NR-1:0] keys = '0, ref_mat = '0;
`ifdef KEYSCAN_DEBOUNCE_EN
  int dcnt[NC][NR] = '{default: 0};
`endif
  typedef struct {int cy; int col; int row; logic p;} ev_t;
  ev_t evq[$];
  int checks = 0, failures = 0, exp_col = 0, cyc = 0, last_req = -1, last_gap = 0;

  keyboard_matrix_scanner #(.N_COLS(NC), .N_ROWS(NR), .SCAN_INTERVAL(SI), .SETTLE_CYCLES(ST)) dut (
    .clk(clk), .reset(reset), .bus_req(bus_req), .bus_ack(bus_ack), .bus_release(bus_release),
    .col_drive(col_drive), .row_in(row_in), .key_strobe(key_strobe), .key_pressed(key_pressed),
    .key_col(key_col), .key_row(key_row), .scan_col(scan_col)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (reset && key_strobe) evq.push_back('{cyc, int'(key_col), int'(key_row), key_pressed});

  // Physical matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = '1;
    for (int c = 0; c < NC; c++) if (!col_drive[c]) row_in = row_in & ~keys[c];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic do_scan(input int d);
    int rows[$];
    logic pv[$];
    int n = 0, r0;
    logic [NC-1:0] drv = ~(NC'(1) << exp_col);
    for (int r = 0; r < NR; r++) begin
`ifdef KEYSCAN_DEBOUNCE_EN
      dcnt[exp_col][r] = keys[exp_col][r] != ref_mat[exp_col][r] ? dcnt[exp_col][r] + 1 : 0;
      if (dcnt[exp_col][r] == DS) begin
        rows.push_back(r); pv.push_back(keys[exp_col][r]);
        ref_mat[exp_col][r] = keys[exp_col][r]; dcnt[exp_col][r] = 0;
      end
`else
      if (keys[exp_col][r] != ref_mat[exp_col][r]) begin
        rows.push_back(r); pv.push_back(keys[exp_col][r]);
        ref_mat[exp_col][r] = keys[exp_col][r];
      end
`endif
    end
    while (!bus_req && n < SI + 50) begin @(negedge clk); n++; end
    checks++;
    if (bus_req !== 1'b1) begin
      failures++; $display("FAIL req_timeout col=%0d bus_req=%b required 1", exp_col, bus_req); return;
    end
    r0 = cyc;
    if (last_req >= 0) begin
      checks++;
      if (r0 - last_req != last_gap) begin
        failures++; $display("FAIL req_spacing got %0d required %0d", r0 - last_req, last_gap);
      end
    end
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      checks++;
      if (bus_req !== 1'b1 || col_drive !== '1 || bus_release !== 1'b0) begin
        failures++; $display("FAIL ack_wait req=%b drive=%h rel=%b required 1/ff/0", bus_req, col_drive, bus_release);
      end
    end
    bus_ack = 1; @(negedge clk);
    checks++;
    if (col_drive !== drv || bus_release !== 1'b1) begin
      failures++; $display("FAIL col_drive got %h/%b required %h/1", col_drive, bus_release, drv);
    end
    for (int i = 0; i < ST; i++) begin bus_ack = 1'($urandom_range(0, 1)); @(negedge clk); end
    checks++;
    if (col_drive !== drv || bus_release !== 1'b1 || key_strobe !== 1'b0) begin
      failures++; $display("FAIL sample_hold got %h/%b required %h/1", col_drive, bus_release, drv);
    end
    bus_ack = 0; @(negedge clk);
    checks++;
    if (col_drive !== '1 || bus_release !== 1'b0 || bus_req !== 1'b0 || key_strobe !== 1'b0) begin
      failures++; $display("FAIL release got drive=%h rel=%b req=%b stb=%b required ff/0/0/0", col_drive, bus_release, bus_req, key_strobe);
    end
    foreach (rows[i]) begin
      @(negedge clk);
      checks++;
      if (key_strobe !== 1'b1 || key_pressed !== pv[i] || key_col !== 3'(exp_col) || key_row !== 3'(rows[i])) begin
        failures++;
        $display("FAIL event got stb=%b p=%b c=%0d r=%0d required 1/%b/%0d/%0d", key_strobe, key_pressed, key_col, key_row, pv[i], exp_col, rows[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (key_strobe !== 1'b0 || scan_col !== 3'((exp_col + 1) % NC)) begin
      failures++; $display("FAIL scan_done got stb=%b scan_col=%0d required 0/%0d", key_strobe, scan_col, (exp_col + 1) % NC);
    end
    last_req = r0;
    last_gap = d + 3 + ST + rows.size() + SI;
    exp_col = (exp_col + 1) % NC;
  endtask

  task automatic do_round;
    while (exp_col != 0) do_scan(0);
    repeat (NC) do_scan(0);
  endtask

  task automatic release_reset;
    int n = 0;
    @(negedge clk); reset = 1;
    while (!bus_req && n < SI + 20) begin @(negedge clk); n++; end
    checks++;
    if (n != SI) begin failures++; $display("FAIL first_req after %0d cycles required %0d", n, SI); end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (col_drive !== 8'hFF || bus_req !== 0 || bus_release !== 0 || scan_col !== 0) begin
      failures++; $display("FAIL reset_bus got drive=%h req=%b rel=%b col=%0d required ff/0/0/0", col_drive, bus_req, bus_release, scan_col);
    end
    checks++;
    if (key_strobe !== 0 || key_pressed !== 0 || key_col !== 0 || key_row !== 0) begin
      failures++; $display("FAIL reset_key got %b%b c=%0d r=%0d required 00/0/0", key_strobe, key_pressed, key_col, key_row);
    end
    release_reset;
  endtask

  task automatic test_ack_hold;
    do_scan(1000);
  endtask

  task automatic test_press_release;
    int n0;
    do_round;
    keys[2][5] = 1'b1; n0 = evq.size();
    repeat (DS) do_round;
    checks++;
    if (evq.size() - n0 != 1 || evq[n0].p !== 1'b1 || evq[n0].col != 2 || evq[n0].row != 5) begin
      failures++; $display("FAIL press_2_5 got %0d events first p=%b c=%0d r=%0d required 1 event 1/2/5", evq.size() - n0, evq[n0].p, evq[n0].col, evq[n0].row);
    end
    keys[2][5] = 1'b0; n0 = evq.size();
    repeat (DS) do_round;
    checks++;
    if (evq.size() - n0 != 1 || evq[n0].p !== 1'b0 || evq[n0].col != 2 || evq[n0].row != 5) begin
      failures++; $display("FAIL release_2_5 got %0d events first p=%b required 1 event 0/2/5", evq.size() - n0, evq[n0].p);
    end
  endtask

  task automatic test_back_to_back;
    int n0;
    keys[4] = 8'b1000_1001; n0 = evq.size();
    repeat (DS) do_round;
    checks++;
    if (evq.size() - n0 != 3 || evq[n0].row != 0 || evq[n0+1].row != 3 || evq[n0+2].row != 7 ||
        evq[n0+1].cy != evq[n0].cy + 1 || evq[n0+2].cy != evq[n0].cy + 2) begin
      failures++; $display("FAIL multi_col4 got %0d events rows %0d,%0d,%0d required 3 consecutive rows 0,3,7", evq.size() - n0, evq[n0].row, evq[n0+1].row, evq[n0+2].row);
    end
    keys[4] = '0;
    repeat (DS) do_round;
  endtask

`ifdef KEYSCAN_DEBOUNCE_EN
  task automatic test_debounce;
    int n0 = evq.size();
    int pat[5] = '{1, 0, 1, 1, 1};
    for (int i = 0; i < 5; i++) begin
      keys[1][0] = 1'(pat[i]);
      do_round;
      if (i == 3) begin
        checks++;
        if (evq.size() != n0) begin failures++; $display("FAIL bounce_early got %0d events required 0", evq.size() - n0); end
      end
    end
    checks++;
    if (evq.size() - n0 != 1 || evq[n0].p !== 1'b1 || evq[n0].col != 1 || evq[n0].row != 0) begin
      failures++; $display("FAIL bounce_press got %0d events required 1 press at 1/0", evq.size() - n0);
    end
    n0 = evq.size();
    keys[1][0] = 0; repeat (2) do_round;
    keys[1][0] = 1; do_round;
    checks++;
    if (evq.size() != n0) begin failures++; $display("FAIL glitch got %0d events required 0", evq.size() - n0); end
    keys[1][0] = 0;
    repeat (DS) do_round;
  endtask
`endif

  task automatic test_random;
    int c, r;
    while (exp_col != 0) do_scan(0);
    keys[0] = ~ref_mat[0];
    do_scan(0);
    repeat (48) begin
      c = $urandom_range(0, NC - 1); r = $urandom_range(0, NR - 1);
      if ($urandom_range(0, 3) == 0) keys[c] = NR'($urandom);
      else keys[c][r] = ~keys[c][r];
      do_scan($urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    keys[2][1] = 1'b1;
    while (exp_col != 2) do_scan(0);
    while (!bus_req && n < SI + 50) begin @(negedge clk); n++; end
    bus_ack = 1; @(negedge clk); bus_ack = 0;
    checks++;
    if (col_drive !== 8'hFB) begin failures++; $display("FAIL mid_drive got %h required fb", col_drive); end
    #2 reset = 0;
    #1;
    checks++;
    if (col_drive !== 8'hFF || bus_release !== 1'b0 || bus_req !== 1'b0) begin
      failures++; $display("FAIL async_reset got drive=%h rel=%b req=%b required ff/0/0", col_drive, bus_release, bus_req);
    end
    ref_mat = '0; exp_col = 0; last_req = -1;
`ifdef KEYSCAN_DEBOUNCE_EN
    dcnt = '{default: 0};
`endif
    @(negedge clk);
    checks++;
    if (key_strobe !== 1'b0 || scan_col !== 3'd0) begin
      failures++; $display("FAIL reset_hold got stb=%b scan_col=%0d required 0/0", key_strobe, scan_col);
    end
    release_reset;
    repeat (DS) do_round;
  endtask

  initial begin
    test_reset;
    test_ack_hold;
    test_press_release;
    test_back_to_back;
`ifdef KEYSCAN_DEBOUNCE_EN
    test_debounce;
`endif
    test_random;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
